adder_stim_checker: RTL and testbench
=====================================

Name: adder_stim_checker

Overview:
- Drives the operand inputs of the conditional add/subtract arithmetic unit and checks its sum output against an internal reference model.
- Runs a fixed-length campaign of directed vectors followed by LFSR-generated vectors, then reports pass/fail, the error count and the first failing index.
- Sits beside the arithmetic unit in self-test wrappers and in simulation-only top levels.

Parameters:
WIDTH, 32, operand/sum width; must equal the arithmetic unit's datapath width.
NUM_TXN, 16, transactions per campaign (>=1).
LATENCY, 0, extra cycles between operand update and valid sum (0 = combinational unit).
SEED, 32'hACE1_2024, LFSR seed (nonzero).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  begin campaign (sampled in IDLE or DONE)
a  out  WIDTH  operand 1 to arithmetic unit (registered)
b  out  WIDTH  operand 2 to arithmetic unit (registered)
sum  in  WIDTH  result from arithmetic unit
busy  out  1  campaign in progress
done  out  1  campaign finished; held until start or rst
pass  out  1  valid with done; 1 iff err_cnt==0
txn_cnt  out  $clog2(NUM_TXN+1)  transactions checked
err_cnt  out  $clog2(NUM_TXN+1)  mismatches seen
first_err_idx  out  $clog2(NUM_TXN+1)  index of first mismatch; all-ones if none

Behaviour:
- Reset: a=0, b=0, busy=0, done=0, pass=0, txn_cnt=0, err_cnt=0, first_err_idx=all-ones, FSM=IDLE, LFSR=SEED. Reset mid-campaign aborts and yields exactly these values on the next cycle.
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
  - IDLE: on start, go to DRIVE; busy=1 from that edge.
  - DRIVE (1 cycle): a/b load vector k on the exiting edge; go to WAIT if LATENCY>0, else CHECK.
  - WAIT: exactly LATENCY cycles, then CHECK.
  - CHECK (1 cycle): compare sum with the registered expected value.
    - Mismatch: err_cnt++; if this is the first mismatch, first_err_idx=k.
    - txn_cnt++ in all cases.
    - Then go to DRIVE if k+1<NUM_TXN; otherwise go to DONE with busy=0, done=1, pass=(err_cnt==0 including this check).
  - DONE: hold all outputs. start clears counters, first_err_idx, done and pass, reseeds the LFSR, and goes to DRIVE.
- start is ignored in DRIVE/WAIT/CHECK.
- Per-transaction cost is 2+LATENCY cycles. done rises 1+NUM_TXN*(2+LATENCY) cycles after the start-sampling edge.
- Vectors:
  - k=0..4 directed: (0,0), (1,5), (2,10), (2,11), (all-ones,1).
  - If NUM_TXN<5, only the first NUM_TXN directed vectors are used.
  - k>=5: the LFSR advances once per DRIVE. a=lfsr; b = {28'b0, lfsr[3:0]} if lfsr[31], else lfsr rotated left by 7. This mixes small and large b values.
  - LFSR: 32-bit Galois, polynomial 0x80200003, zero-extended/truncated to WIDTH.
- Reference model: exp = (a>=2 && (b<=10 || a==0)) ? a+b : a-b, unsigned, modulo 2^WIDTH, carry/borrow discarded. exp is registered in DRIVE together with a/b.
- Counters never exceed NUM_TXN, so no saturation logic is needed.
- sum is sampled only in CHECK; X/garbage in other states has no effect.

Decomposition:
- Package adder_pkg holds:
  - the state enum;
  - the LFSR polynomial and default seed;
  - the directed vector constant array;
  - function automatic adder_expected(a,b), parameterised by width via a typedef logic [31:0] word_t.
- Sub-module lfsr32 (clk, rst, load, seed, advance, value), reusable by other stimulus blocks.
- The FSM, counters and compare logic live in adder_stim_checker.

Test Plan:
- Correct combinational unit, NUM_TXN=8, LATENCY=0, start pulse at cycle 0 -> done=1 at cycle 17, pass=1, txn_cnt=8, err_cnt=0, first_err_idx=all-ones.
- Faulty unit (sum=a+b always), NUM_TXN=5 -> mismatches at k=1 (exp 0xFFFFFFFC, got 6) and k=3 (exp 0xFFFFFFF7, got 13); err_cnt=2, first_err_idx=1, pass=0. k=4 matches at 0, checking wrap.
- Unit with 2-register pipeline, LATENCY=2, NUM_TXN=8 -> pass=1, done at cycle 33. The same unit with LATENCY=0 -> pass=0.
- rst asserted during CHECK of k=3 -> next cycle all outputs at reset values and FSM=IDLE; a subsequent start runs a full campaign with an identical operand sequence.
- start pulsed while busy -> no effect on sequence or counters. start in DONE -> counters cleared next cycle; the LFSR sequence for k>=5 repeats bit-exact.
- NUM_TXN=3 -> only vectors (0,0), (1,5), (2,10) are driven; done at cycle 7.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types, constants and the reference model for the adder stimulus/checker.
// The model works on 32-bit words; narrower datapaths zero-extend into it.
package adder_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam word_t LFSR_POLY         = 32'h8020_0003;
  localparam word_t LFSR_DEFAULT_SEED = 32'hACE1_2024;

  localparam int NUM_DIRECTED = 5;
  localparam word_t DIR_A [NUM_DIRECTED] = '{32'd0, 32'd1, 32'd2, 32'd2, 32'hFFFF_FFFF};
  localparam word_t DIR_B [NUM_DIRECTED] = '{32'd0, 32'd5, 32'd10, 32'd11, 32'd1};

  // Conditional add/subtract, carry and borrow discarded.
  function automatic word_t adder_expected(input word_t a, input word_t b);
    return (a >= 32'd2 && (b <= 32'd10 || a == 32'd0)) ? a + b : a - b;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR (right-shifting) with synchronous reseed and step enable.
module lfsr32
  import adder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      value <= seed;
    end else if (advance) begin
      value <= {1'b0, value[31:1]} ^ (value[0] ? LFSR_POLY : 32'd0);
    end
  end

endmodule

// File: rtl/adder_stim_checker.sv
// Drives operands into the add/subtract unit, compares its sum against the
// reference model and reports a pass/fail summary. WIDTH is at most 32.
module adder_stim_checker
  import adder_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int          NUM_TXN = 16,
  parameter int          LATENCY = 0,
  parameter logic [31:0] SEED    = LFSR_DEFAULT_SEED
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [WIDTH-1:0]             a,
  output logic [WIDTH-1:0]             b,
  input  logic [WIDTH-1:0]             sum,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(NUM_TXN+1)-1:0] txn_cnt,
  output logic [$clog2(NUM_TXN+1)-1:0] err_cnt,
  output logic [$clog2(NUM_TXN+1)-1:0] first_err_idx,
  output state_t                       dbg_state
);

  localparam int CW = $clog2(NUM_TXN + 1);
  localparam int WW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CW-1:0] LAST_K    = CW'(NUM_TXN - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t            state, state_nx;
  logic [CW-1:0]     k;
  logic [WW-1:0]     wait_cnt;
  logic [WIDTH-1:0]  exp_sum;
  logic [31:0]       lfsr_value;
  logic              run_start, lfsr_step, mismatch;
  logic [CW-1:0]     err_nx;
  logic [2:0]        dir_idx;
  word_t             vec_a, vec_b, rnd_b;
  logic [WIDTH-1:0]  va_w, vb_w;

  assign run_start = start && (state == S_IDLE || state == S_DONE);
  assign lfsr_step = (state == S_DRIVE) && (int'(k) >= NUM_DIRECTED);

  lfsr32 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (run_start),
    .seed    (SEED),
    .advance (lfsr_step),
    .value   (lfsr_value)
  );

  // Random vectors use the current LFSR value; the step happens on the same edge.
  always_comb begin
    dir_idx = 3'(k);
    rnd_b   = lfsr_value[31] ? {28'd0, lfsr_value[3:0]}
                             : {lfsr_value[24:0], lfsr_value[31:25]};
    vec_a   = lfsr_value;
    vec_b   = rnd_b;
    if (int'(k) < NUM_DIRECTED) begin
      vec_a = DIR_A[dir_idx];
      vec_b = DIR_B[dir_idx];
    end
    va_w = WIDTH'(vec_a);
    vb_w = WIDTH'(vec_b);
  end

  assign mismatch = (sum != exp_sum);
  assign err_nx   = err_cnt + CW'(mismatch);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_DRIVE;
      S_DRIVE:        state_nx = (LATENCY > 0) ? S_WAIT : S_CHECK;
      S_WAIT:         if (wait_cnt == LAST_WAIT) state_nx = S_CHECK;
      S_CHECK:        state_nx = (k == LAST_K) ? S_DONE : S_DRIVE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a             <= '0;
      b             <= '0;
      exp_sum       <= '0;
      k             <= '0;
      wait_cnt      <= '0;
      txn_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      pass          <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            k             <= '0;
            txn_cnt       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '1;
            pass          <= 1'b0;
          end
        end
        S_DRIVE: begin
          a        <= va_w;
          b        <= vb_w;
          exp_sum  <= WIDTH'(adder_expected(word_t'(va_w), word_t'(vb_w)));
          wait_cnt <= '0;
        end
        S_WAIT: wait_cnt <= wait_cnt + WW'(1);
        S_CHECK: begin
          txn_cnt <= txn_cnt + CW'(1);
          err_cnt <= err_nx;
          if (mismatch && err_cnt == '0) first_err_idx <= k;
          if (k == LAST_K) pass <= (err_nx == '0);
          else             k    <= k + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_adder_stim_checker.sv
// Bench for adder_stim_checker: four instances face correct, faulty, pipelined
// and short-campaign arithmetic units; a scoreboard checks operands and summaries.
`timescale 1ns/1ps
module tb_adder_stim_checker;
  import adder_pkg::*;

  localparam int W = 40;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DUT signals
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic [31:0] a0, b0, sum0, a1, b1, sum1, a2, b2, sum2, a3, b3, sum3;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic        busy2, done2, pass2, busy3, done3, pass3;
  logic [3:0]  txn0, err0, fe0, txn1, err1, fe1;
  logic [2:0]  txn2, err2, fe2;
  logic [1:0]  txn3, err3, fe3;
  state_t      st0, st1, st2, st3;

  // arithmetic units around the DUTs
  function automatic logic [31:0] unit_f(input logic [31:0] x, input logic [31:0] y);
    return (x >= 32'd2 && y <= 32'd10) ? x + y : x - y;
  endfunction

  int mode0 = 0;  // 0 correct, 1 always-add, 2 two-stage pipeline
  logic [31:0] p0_1, p0_2, p1_1, p1_2;
  always @(posedge clk) begin
    p0_1 <= unit_f(a0, b0);
    p0_2 <= p0_1;
    p1_1 <= unit_f(a1, b1);
    p1_2 <= p1_1;
  end
  assign sum0 = (mode0 == 0) ? unit_f(a0, b0) : (mode0 == 1) ? a0 + b0 : p0_2;
  assign sum1 = p1_2;
  assign sum2 = a2 + b2;
  assign sum3 = unit_f(a3, b3);

  adder_stim_checker #(.WIDTH(32), .NUM_TXN(8), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .sum(sum0),
    .busy(busy0), .done(done0), .pass(pass0), .txn_cnt(txn0), .err_cnt(err0),
    .first_err_idx(fe0), .dbg_state(st0));
  adder_stim_checker #(.WIDTH(32), .NUM_TXN(8), .LATENCY(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .sum(sum1),
    .busy(busy1), .done(done1), .pass(pass1), .txn_cnt(txn1), .err_cnt(err1),
    .first_err_idx(fe1), .dbg_state(st1));
  adder_stim_checker #(.WIDTH(32), .NUM_TXN(5), .LATENCY(0)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .sum(sum2),
    .busy(busy2), .done(done2), .pass(pass2), .txn_cnt(txn2), .err_cnt(err2),
    .first_err_idx(fe2), .dbg_state(st2));
  adder_stim_checker #(.WIDTH(32), .NUM_TXN(3), .LATENCY(0)) u3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .sum(sum3),
    .busy(busy3), .done(done3), .pass(pass3), .txn_cnt(txn3), .err_cnt(err3),
    .first_err_idx(fe3), .dbg_state(st3));

  logic       done_v [4];
  logic       pass_v [4];
  logic [7:0] txn_v [4], err_v [4], fe_v [4];
  assign done_v[0] = done0;  assign pass_v[0] = pass0;
  assign done_v[1] = done1;  assign pass_v[1] = pass1;
  assign done_v[2] = done2;  assign pass_v[2] = pass2;
  assign done_v[3] = done3;  assign pass_v[3] = pass3;
  assign txn_v[0] = 8'(txn0); assign err_v[0] = 8'(err0); assign fe_v[0] = 8'(fe0);
  assign txn_v[1] = 8'(txn1); assign err_v[1] = 8'(err1); assign fe_v[1] = 8'(fe1);
  assign txn_v[2] = 8'(txn2); assign err_v[2] = 8'(err2); assign fe_v[2] = 8'(fe2);
  assign txn_v[3] = 8'(txn3); assign err_v[3] = 8'(err3); assign fe_v[3] = 8'(fe3);

  // hand-computed vectors: directed set, then LFSR from 0xACE12024
  logic [31:0] va_t [8] = '{32'h0, 32'h1, 32'h2, 32'h2, 32'hFFFF_FFFF,
                            32'hACE1_2024, 32'h5670_9012, 32'h2B38_4809};
  logic [31:0] vb_t [8] = '{32'h0, 32'h5, 32'hA, 32'hB, 32'h1,
                            32'h4, 32'h3848_092B, 32'h9C24_0495};

  // scoreboard
  logic [63:0]  ops_q [$];
  logic [W-1:0] exp_q [$];
  int           start_cyc [4] = '{0, 0, 0, 0};

  function automatic logic [W-1:0] rec(input int id, input logic p, input logic [7:0] t,
                                       input logic [7:0] e, input logic [7:0] f,
                                       input logic [7:0] lat);
    return {7'(id), p, t, e, f, lat};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_start(input int id, input logic v);
    case (id)
      0: start0 = v;
      1: start1 = v;
      2: start2 = v;
      default: start3 = v;
    endcase
  endtask

  task automatic pulse_start(input int id);
    @(negedge clk);
    set_start(id, 1'b1);
    @(posedge clk);
    start_cyc[id] = cyc;
    @(negedge clk);
    set_start(id, 1'b0);
  endtask

  task automatic push_ops(input int n);
    for (int k = 0; k < n; k++) ops_q.push_back({va_t[k], vb_t[k]});
  endtask

  task automatic wait_done(input int id, input int budget);
    int n = 0;
    while (done_v[id] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_v[id] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout_dut%0d: done=%b after %0d cycles, required 1", id, done_v[id], budget);
    end
  endtask

  task automatic check_reset_u0(input string tag);
    chk({tag, "_a"}, 64'(a0), 64'h0);
    chk({tag, "_b"}, 64'(b0), 64'h0);
    chk({tag, "_busy"}, 64'(busy0), 64'h0);
    chk({tag, "_done"}, 64'(done0), 64'h0);
    chk({tag, "_pass"}, 64'(pass0), 64'h0);
    chk({tag, "_txn"}, 64'(txn0), 64'h0);
    chk({tag, "_err"}, 64'(err0), 64'h0);
    chk({tag, "_first"}, 64'(fe0), 64'hF);
    chk({tag, "_state"}, 64'(st0), 64'(S_IDLE));
  endtask

  // monitor: operands presented by u0 during each CHECK
  initial begin : ops_mon
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (st0 == S_CHECK) begin
        if (ops_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ops_unexpected: got 0x%0h, expected none", {a0, b0});
        end else begin
          e = ops_q.pop_front();
          chk("ops_u0", {a0, b0}, e);
        end
      end
    end
  end

  // monitor: campaign summary on each rising done
  initial begin : status_mon
    logic         prev [4];
    logic [W-1:0] e, got;
    for (int i = 0; i < 4; i++) prev[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (done_v[i] === 1'b1 && !prev[i]) begin
          got = rec(i, pass_v[i], txn_v[i], err_v[i], fe_v[i], 8'(cyc - start_cyc[i]));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL status_unexpected dut%0d: got 0x%0h, expected none", i, got);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("status_dut%0d", i), 64'(got), 64'(e));
          end
        end
        prev[i] = (done_v[i] === 1'b1);
      end
    end
  end

  // stimulus
  initial begin : main
    int n;
    repeat (2) @(negedge clk);
    check_reset_u0("init");
    rst = 1'b0;

    // correct unit, with a start pulse while busy
    mode0 = 0;
    push_ops(8);
    exp_q.push_back(rec(0, 1'b1, 8'd8, 8'd0, 8'h0F, 8'd17));
    pulse_start(0);
    repeat (5) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, 60);

    // restart from DONE: counters clear at once, sequence repeats
    push_ops(8);
    exp_q.push_back(rec(0, 1'b1, 8'd8, 8'd0, 8'h0F, 8'd17));
    pulse_start(0);
    chk("restart_txn", 64'(txn0), 64'h0);
    chk("restart_err", 64'(err0), 64'h0);
    chk("restart_first", 64'(fe0), 64'hF);
    chk("restart_done", 64'(done0), 64'h0);
    chk("restart_pass", 64'(pass0), 64'h0);
    chk("restart_busy", 64'(busy0), 64'h1);
    wait_done(0, 60);

    // always-add unit: mismatches at k=1,3,6,7
    mode0 = 1;
    push_ops(8);
    exp_q.push_back(rec(0, 1'b0, 8'd8, 8'd4, 8'h01, 8'd17));
    pulse_start(0);
    wait_done(0, 60);

    // abort with reset during CHECK of k=3
    mode0 = 0;
    push_ops(4);
    pulse_start(0);
    n = 0;
    while (!(st0 == S_CHECK && txn0 == 4'd3) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_k3", 64'(st0 == S_CHECK && txn0 == 4'd3), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_u0("abort");
    rst = 1'b0;

    // pipelined unit on a zero-latency checker: stale sums everywhere but k=0
    mode0 = 2;
    repeat (3) @(negedge clk);
    push_ops(8);
    exp_q.push_back(rec(0, 1'b0, 8'd8, 8'd7, 8'h01, 8'd17));
    pulse_start(0);
    wait_done(0, 60);

    // pipelined unit with matching latency
    exp_q.push_back(rec(1, 1'b1, 8'd8, 8'd0, 8'h0F, 8'd33));
    pulse_start(1);
    wait_done(1, 100);

    // five-vector campaign against always-add
    exp_q.push_back(rec(2, 1'b0, 8'd5, 8'd2, 8'h01, 8'd11));
    pulse_start(2);
    wait_done(2, 60);

    // three-vector campaign ends on (2,10)
    exp_q.push_back(rec(3, 1'b1, 8'd3, 8'd0, 8'h03, 8'd7));
    pulse_start(3);
    wait_done(3, 60);
    chk("short_last_a", 64'(a3), 64'h2);
    chk("short_last_b", 64'(b3), 64'hA);

    repeat (2) @(negedge clk);
    chk("status_queue_empty", 64'(exp_q.size()), 64'h0);
    chk("ops_queue_empty", 64'(ops_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
